// File: rtl/seq_detect_ctrl.sv
// ----------------------------------------------------------------------------
// seq_detect_ctrl
//
// Run-control block for a serial-bit pattern detector. A PAT_W-bit pattern is
// loaded in IDLE, detection is armed with start, and every accepted bit of the
// valid-qualified serial stream is shifted into a history register. A match
// sends the FSM to MATCH for one cycle (Moore pulse) and bumps a saturating
// match counter. Matching is overlapping or non-overlapping. A non-zero target
// stops the run in DONE once that many matches have been seen.
//
// Optional feature (macro SEQ_DETECT_CTRL_TIMEOUT_EN):
//   adds parameter TO_CYC and output timeout. A cycle counter runs in RUN and
//   forces DONE with timeout=1 when no hit arrives for TO_CYC cycles.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-low reset
//   cfg_load     in   capture cfg_* (IDLE only)
//   cfg_pattern  in   [PAT_W] pattern, MSB = oldest bit
//   cfg_overlap  in   1 = overlapping matches
//   cfg_target   in   [CNT_W] matches before DONE, 0 = unlimited
//   start        in   arm detection (IDLE or DONE)
//   abort        in   return to IDLE from any state
//   x            in   serial data bit
//   x_valid      in   x qualifier
//   busy         out  RUN or MATCH
//   match        out  MATCH state
//   match_cnt    out  [CNT_W] matches since the last start
//   done         out  DONE state
//   timeout      out  (macro only) DONE was reached by timeout
// ----------------------------------------------------------------------------
module seq_detect_ctrl #(
    parameter int unsigned       PAT_W   = 3,
    parameter int unsigned       CNT_W   = 4,
    parameter logic [PAT_W-1:0]  RST_PAT = 3'b101
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
    ,
    parameter int unsigned       TO_CYC  = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             start,
    input  logic             abort,
    input  logic             x,
    input  logic             x_valid,
    output logic             busy,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
    output logic             timeout,
`endif
    output logic             done
);

    localparam int unsigned FILL_W = $clog2(PAT_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_MATCH,
        S_DONE
    } state_e;

    state_e             state_q,   state_d;
    logic [PAT_W-1:0]   pattern_q, pattern_d;
    logic               overlap_q, overlap_d;
    logic [CNT_W-1:0]   target_q,  target_d;
    logic [PAT_W-1:0]   hist_q,    hist_d;
    logic [FILL_W-1:0]  fill_q,    fill_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;

`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
    localparam int unsigned TO_W = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;
    logic [TO_W-1:0]    to_cnt_q,  to_cnt_d;
    logic               timeout_q, timeout_d;
`endif

    logic               active;
    logic               accept;
    logic               hit;
    logic               launch;
    logic               target_reached;
    logic [PAT_W-1:0]   hist_shift;
    logic [FILL_W-1:0]  fill_next;
    logic [CNT_W-1:0]   cnt_inc;

    // Datapath helpers. The hit looks at the history including the bit being
    // accepted this cycle, so the MATCH state follows the completing edge.
    assign active     = (state_q == S_RUN) || (state_q == S_MATCH);
    assign accept     = active && x_valid;
    assign hist_shift = {hist_q[PAT_W-2:0], x};
    assign fill_next  = (fill_q >= FILL_W'(PAT_W)) ? FILL_W'(PAT_W) : fill_q + FILL_W'(1);
    assign hit        = accept && (fill_q >= FILL_W'(PAT_W - 1)) && (hist_shift == pattern_q);
    assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign launch     = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign target_reached = (target_q != '0) && (cnt_q == target_q);

    // NOTE: every signal written here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        overlap_d = overlap_q;
        target_d  = target_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
        timeout_d = timeout_q;
`endif

        if (abort) begin
            state_d = S_IDLE;
            hist_d  = '0;
            fill_d  = '0;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
            timeout_d = 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    // Config is only writable while idle; a simultaneous start
                    // runs with the freshly latched values.
                    if (state_q == S_IDLE && cfg_load) begin
                        pattern_d = cfg_pattern;
                        overlap_d = cfg_overlap;
                        target_d  = cfg_target;
                    end
                    if (launch) begin
                        state_d = S_RUN;
                        hist_d  = '0;
                        fill_d  = '0;
                        cnt_d   = '0;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
                        to_cnt_d  = '0;
                        timeout_d = 1'b0;
`endif
                    end
                end

                S_RUN, S_MATCH: begin
                    if (accept) begin
                        hist_d = hist_shift;
                        fill_d = fill_next;
                    end
                    if (state_q == S_MATCH && target_reached) begin
                        state_d = S_DONE;
                    end else if (hit) begin
                        state_d = S_MATCH;
                        cnt_d   = cnt_inc;
                        // Non-overlap: the matched bits may not seed the next match.
                        if (!overlap_q) fill_d = '0;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
                        to_cnt_d = '0;
`endif
                    end else if (state_q == S_MATCH) begin
                        state_d = S_RUN;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
                    end else if (to_cnt_q == TO_W'(TO_CYC - 1)) begin
                        state_d   = S_DONE;
                        timeout_d = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
`endif
                    end
                end

                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            pattern_q <= RST_PAT;
            overlap_q <= 1'b0;
            target_q  <= '0;
            hist_q    <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            overlap_q <= overlap_d;
            target_q  <= target_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // Moore outputs: decoded from registered state only.
    assign busy      = (state_q == S_RUN) || (state_q == S_MATCH);
    assign match     = (state_q == S_MATCH);
    assign done      = (state_q == S_DONE);
    assign match_cnt = cnt_q;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
    assign timeout   = timeout_q;
`endif

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seq_detect_ctrl
//
// Directed scenarios followed by a randomized run. A reference model built on
// a bit queue predicts busy/match/done/match_cnt after every clock edge.
// ----------------------------------------------------------------------------
module tb_seq_detect_ctrl;

    localparam int unsigned PAT_W = 3;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic             cfg_overlap;
    logic [CNT_W-1:0] cfg_target;
    logic             start;
    logic             abort;
    logic             x;
    logic             x_valid;
    logic             busy;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             done;

    always #5 clk = ~clk;

    seq_detect_ctrl #(
        .PAT_W   (PAT_W),
        .CNT_W   (CNT_W),
        .RST_PAT (3'b101)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .start       (start),
        .abort       (abort),
        .x           (x),
        .x_valid     (x_valid),
        .busy        (busy),
        .match       (match),
        .match_cnt   (match_cnt),
        .done        (done)
    );

    int n_vec = 0;
    int n_err = 0;
    int pulses = 0;

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_RUN, M_MATCH, M_DONE} mode_t;
    mode_t            m_mode;
    logic [PAT_W-1:0] m_pat;
    logic             m_ovl;
    logic [CNT_W-1:0] m_tgt;
    int               m_cnt;
    bit               m_bits[$];   // bits eligible to form the next match, oldest first

    function automatic logic window_hits();
        logic [PAT_W-1:0] w = '0;
        if (m_bits.size() != PAT_W) return 1'b0;
        for (int i = 0; i < PAT_W; i++) w = {w[PAT_W-2:0], m_bits[i]};
        return w == m_pat;
    endfunction

    // Applies the current inputs as one clock edge to the model.
    task automatic model_step();
        logic got;
        if (!rst) begin
            m_mode = M_IDLE; m_pat = 3'b101; m_ovl = 1'b0; m_tgt = '0;
            m_cnt = 0; m_bits.delete();
        end else if (abort) begin
            m_mode = M_IDLE; m_bits.delete();
        end else if (m_mode == M_IDLE || m_mode == M_DONE) begin
            if (m_mode == M_IDLE && cfg_load) begin
                m_pat = cfg_pattern; m_ovl = cfg_overlap; m_tgt = cfg_target;
            end
            if (start) begin
                m_mode = M_RUN; m_bits.delete(); m_cnt = 0;
            end
        end else if (m_mode == M_MATCH && m_tgt != 0 && m_cnt == int'(m_tgt)) begin
            m_mode = M_DONE;
        end else begin
            got = 1'b0;
            if (x_valid) begin
                m_bits.push_back(x);
                if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
                got = window_hits();
            end
            if (got) begin
                if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                m_mode = M_MATCH;
                if (!m_ovl) m_bits.delete();
            end else begin
                m_mode = M_RUN;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: model and DUT see the same edge, outputs compared 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("busy",      busy,      (m_mode == M_RUN || m_mode == M_MATCH));
        check("match",     match,     (m_mode == M_MATCH));
        check("done",      done,      (m_mode == M_DONE));
        check("match_cnt", match_cnt, m_cnt);
        if (match === 1'b1) pulses++;
    endtask

    task automatic bit_in(input logic b);
        x = b; x_valid = 1'b1; tick(); x_valid = 1'b0;
    endtask

    task automatic load_start(input logic [PAT_W-1:0] p, input logic o, input logic [CNT_W-1:0] t);
        cfg_load = 1'b1; cfg_pattern = p; cfg_overlap = o; cfg_target = t; start = 1'b1;
        tick();
        cfg_load = 1'b0; start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1; tick(); abort = 1'b0;
    endtask

    logic [4:0] stream_a;
    logic [8:0] stream_b;

    initial begin
        rst = 1'b0; cfg_load = 1'b0; cfg_pattern = '0; cfg_overlap = 1'b0;
        cfg_target = '0; start = 1'b0; abort = 1'b0; x = 1'b0; x_valid = 1'b0;

        // Reset and defaults
        tick(); tick();
        rst = 1'b1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_cnt",  match_cnt, 0);
        start = 1'b1; tick(); start = 1'b0;
        check("start_busy", busy, 1'b1);

        // Non-overlap with reset pattern 101
        stream_a = 5'b10101;
        pulses = 0;
        for (int i = 4; i >= 0; i--) begin
            bit_in(stream_a[i]);
            check("novl_pulse_pos", match, (i == 2));
        end
        tick(); tick();
        check("novl_pulses", pulses, 1);
        check("novl_cnt", match_cnt, 1);
        do_abort();

        // Overlap
        load_start(3'b101, 1'b1, 4'd0);
        pulses = 0;
        for (int i = 4; i >= 0; i--) begin
            bit_in(stream_a[i]);
            check("ovl_pulse_pos", match, (i == 2 || i == 0));
        end
        tick(); tick();
        check("ovl_pulses", pulses, 2);
        check("ovl_cnt", match_cnt, 2);
        do_abort();
        check("abort_holds_cnt", match_cnt, 2);

        // Target and hold
        load_start(3'b110, 1'b0, 4'd2);
        stream_b = 9'b110110110;
        pulses = 0;
        for (int i = 8; i >= 0; i--) bit_in(stream_b[i]);
        tick(); tick();
        check("tgt_done", done, 1'b1);
        check("tgt_pulses", pulses, 2);
        check("tgt_cnt", match_cnt, 2);
        start = 1'b1; tick(); start = 1'b0;
        check("restart_cnt", match_cnt, 0);
        check("restart_busy", busy, 1'b1);
        do_abort();

        // x_valid gaps
        load_start(3'b101, 1'b0, 4'd0);
        pulses = 0;
        bit_in(1'b1); tick(); tick(); tick();
        bit_in(1'b0); tick(); tick(); tick();
        bit_in(1'b1);
        check("gap_match", match, 1'b1);
        tick(); tick();
        check("gap_pulses", pulses, 1);

        // Abort on the completing bit
        do_abort();
        load_start(3'b101, 1'b0, 4'd0);
        pulses = 0;
        bit_in(1'b1); bit_in(1'b0);
        abort = 1'b1; x = 1'b1; x_valid = 1'b1; tick(); abort = 1'b0; x_valid = 1'b0;
        check("abort_match", match, 1'b0);
        check("abort_busy", busy, 1'b0);
        tick(); tick();
        check("abort_pulses", pulses, 0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst         = ($urandom_range(0, 199) != 0);
            start       = ($urandom_range(0, 11) == 0);
            abort       = ($urandom_range(0, 39) == 0);
            cfg_load    = ($urandom_range(0, 5) == 0);
            cfg_pattern = PAT_W'($urandom);
            cfg_overlap = 1'($urandom);
            cfg_target  = CNT_W'($urandom_range(0, 3));
            x_valid     = ($urandom_range(0, 3) != 0);
            x           = 1'($urandom);
            tick();
        end
        rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_load = 1'b0; x_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
- Run-control block for the serial-bit pattern detectors.
- Loads a programmable PAT_W-bit pattern and arms detection on a valid-qualified serial stream.
- Selects overlapping or non-overlapping matching, counts matches, and stops after a programmed target count.
- Sits between the configuration/test-control logic and the serial input line; produces a Moore match pulse, a match count and done status.

Parameters:
- PAT_W, 3, pattern length in bits (>=2).
- CNT_W, 4, width of the match counter and the target.
- RST_PAT, 3'b101, pattern value after reset (width PAT_W).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-low reset (rst=0 at a rising edge resets).
- cfg_load  in  1  capture cfg_* values; honoured only in IDLE.
- cfg_pattern  in  PAT_W  pattern; MSB is the oldest bit.
- cfg_overlap  in  1  1=overlapping matching, 0=non-overlapping.
- cfg_target  in  CNT_W  matches before DONE; 0=unlimited.
- start  in  1  arm detection.
- abort  in  1  return to IDLE.
- x  in  1  serial data bit.
- x_valid  in  1  x is sampled only when high.
- busy  out  1  high in RUN or MATCH.
- match  out  1  high for exactly the MATCH state cycle.
- match_cnt  out  CNT_W  matches since the last start.
- done  out  1  high in DONE.

Behaviour:
- Reset (rst=0):
  - state=IDLE.
  - pattern=RST_PAT, overlap=0, target=0.
  - hist=0, fill=0, match_cnt=0.
  - busy=match=done=0.
- Outputs are decoded from registered state only (Moore); there is no combinational path from x to match.
- States: IDLE, RUN, MATCH, DONE.
- abort has the highest priority: from any state, next state is IDLE. It clears hist and fill; match_cnt holds its value.
- IDLE:
  - cfg_load latches the config registers.
  - start moves to RUN and clears hist, fill and match_cnt.
  - If cfg_load and start are both high, the config is latched and the new config is used.
- DONE: start moves to RUN (same clearing as from IDLE); cfg_load is ignored.
- In RUN or MATCH: start and cfg_load are ignored.
- Bit acceptance (RUN or MATCH with x_valid=1):
  - hist <= {hist[PAT_W-2:0], x}.
  - fill increments, saturating at PAT_W.
- Hit condition: fill (including the current bit) >= PAT_W and {hist[PAT_W-2:0], x} == pattern.
- On a hit, the next state is MATCH and match_cnt increments at the same edge, saturating at all-ones.
  - Non-overlap: fill is cleared to 0 at that edge.
  - Overlap: fill is kept.
- MATCH lasts one cycle and keeps accepting bits, so no input is lost. Exit from MATCH:
  - to DONE if target != 0 and match_cnt == target;
  - else to MATCH if the current bit hits;
  - else to RUN.
- Latency: the match pulse occurs on the cycle after the edge that accepts the completing bit.
- x_valid=0 means hist and fill hold and no hit is possible.
- DONE holds until start or abort; match_cnt stays readable.

Optional Feature:
- Macro: SEQ_DETECT_CTRL_TIMEOUT_EN.
- With the macro defined:
  - Adds parameter TO_CYC (default 16) and output port timeout (1 bit).
  - A cycle counter clears on start and on every hit, and increments each cycle in RUN.
  - When it reaches TO_CYC-1 in RUN with no hit that cycle, the next state is DONE with timeout=1.
  - timeout clears on start, abort or reset.
- With the macro undefined: no counter, no timeout port, and RUN never exits on its own.

Test Plan:
- Reset and defaults: rst=0 for 2 cycles, then start with pattern 101 (no load) -> after reset busy=0, done=0, match_cnt=0; the following start yields busy=1.
- Non-overlap: overlap=0, target=0, stream 1,0,1,0,1 one bit per cycle -> exactly one match pulse, on the cycle after the 3rd bit; match_cnt=1.
- Overlap: same stream with overlap=1 -> match pulses after the 3rd and 5th bits; match_cnt=2.
- Target and hold: pattern 110, target=2, overlap=0, stream 1,1,0,1,1,0,1,1,0 -> done=1 after the 2nd match; the 3rd occurrence is ignored; match_cnt=2; a later start clears match_cnt to 0 and sets busy=1.
- x_valid gaps and abort:
  - Bits 1,0,1 with x_valid low for 3 cycles between bits -> single match.
  - abort asserted the same cycle as a completing bit -> IDLE, no match pulse.
- Timeout (macro defined, TO_CYC=8): start, then feed all-zero bits -> done=1 and timeout=1 exactly 8 cycles after entering RUN.
